// File: rtl/subpel_pkg.sv
// Shared subpixel-interpolation definitions: pixel/window geometry, derived
// bus widths and the reference-loader state encoding.
package subpel_pkg;

  localparam int PIXEL_W = 8;
  localparam int WIN_DIM = 15;
  localparam int ROW_W   = PIXEL_W * WIN_DIM;   // 120
  localparam int WIN_W   = ROW_W * WIN_DIM;     // 1800
  localparam int IDX_W   = 4;

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(WIN_DIM - 1);

  typedef enum logic [0:0] {
    LD_FILL = 1'b0,
    LD_FULL = 1'b1
  } loader_state_e;

  // True when the row index addresses the final row of a window.
  function automatic logic is_last_row(input logic [IDX_W-1:0] idx);
    return (idx == LAST_ROW);
  endfunction

endpackage

// File: rtl/ref_window_loader_if.sv
// Row-in / window-out stream bundle between the frame fetch path, the
// reference window loader and the interpolator input buffer.
interface ref_window_loader_if;
  import subpel_pkg::*;

  logic [ROW_W-1:0] in_row;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIN_W-1:0] win_data;
  logic             win_valid;
  logic             win_ready;
  logic             err;

  // Environment side: supplies rows, consumes windows.
  modport master (
    output in_row, in_valid, in_last, win_ready,
    input  in_ready, win_data, win_valid, err
  );

  // Loader side.
  modport slave (
    input  in_row, in_valid, in_last, win_ready,
    output in_ready, win_data, win_valid, err
  );

endinterface

// File: rtl/window_bank.sv
// One WIN_DIM x ROW_W window bank: row-addressed write port and a flat,
// registered read of the whole window.
module window_bank
  import subpel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [ROW_W-1:0] wr_row_i,
  output logic [WIN_W-1:0] win_o
);

  logic [ROW_W-1:0] rows_q [WIN_DIM];

  // Row storage: cleared on reset, one row written per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        rows_q[r] <= '0;
      end
    end else if (wr_en_i && (wr_idx_i <= LAST_ROW)) begin
      rows_q[wr_idx_i] <= wr_row_i;
    end
  end

  // Flatten rows onto the window bus, row r at [r*ROW_W +: ROW_W].
  always_comb begin
    win_o = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      win_o[r*ROW_W +: ROW_W] = rows_q[r];
    end
  end

endmodule

// File: rtl/ref_window_loader.sv
// Reference window loader: packs 15 rows into a 15x15 pixel window and hands
// it to the interpolator. Framing errors on in_last produce a one-cycle err.
// Build option REF_LOADER_PINGPONG_EN: two banks, one filling while the other
// is presented; otherwise a single bank with a FILL/FULL state machine.
module ref_window_loader
  import subpel_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  ref_window_loader_if.slave  bus
);

  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic             in_ready_q, in_ready_d;
  logic             win_valid_q, win_valid_d;
  logic             err_q, err_d;

  logic row_xfer_s;
  logic win_xfer_s;
  logic at_last_s;
  logic win_done_s;

  assign row_xfer_s = bus.in_valid && in_ready_q;
  assign win_xfer_s = win_valid_q && bus.win_ready;
  assign at_last_s  = is_last_row(row_idx_q);
  assign win_done_s = row_xfer_s && at_last_s;

  // Row counter and framing check; early in_last restarts the window.
  always_comb begin
    row_idx_d = row_idx_q;
    err_d     = 1'b0;
    if (row_xfer_s) begin
      err_d = (bus.in_last != at_last_s);
      if (at_last_s || bus.in_last) begin
        row_idx_d = 4'd0;
      end else begin
        row_idx_d = row_idx_q + 4'd1;
      end
    end else begin
      row_idx_d = row_idx_q;
    end
  end

`ifdef REF_LOADER_PINGPONG_EN

  logic [1:0]       full_q, full_d;
  logic             fill_sel_q, fill_sel_d;
  logic             pres_sel_q, pres_sel_d;
  logic [WIN_W-1:0] bank_win_s [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    window_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (row_xfer_s && (fill_sel_q == 1'(b))),
      .wr_idx_i (row_idx_q),
      .wr_row_i (bus.in_row),
      .win_o    (bank_win_s[b])
    );
  end

  // Bank bookkeeping: completion fills the write bank, acceptance frees the
  // presented bank; both may happen in the same cycle.
  always_comb begin
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    pres_sel_d = pres_sel_q;
    if (win_xfer_s) begin
      full_d[pres_sel_q] = 1'b0;
      pres_sel_d         = ~pres_sel_q;
    end else begin
      pres_sel_d = pres_sel_q;
    end
    if (win_done_s) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = ~fill_sel_q;
    end else begin
      fill_sel_d = fill_sel_q;
    end
    in_ready_d  = ~(&full_d);
    win_valid_d = full_d[pres_sel_d];
  end

  // Bank select and full flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q     <= 2'b00;
      fill_sel_q <= 1'b0;
      pres_sel_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      pres_sel_q <= pres_sel_d;
    end
  end

  // Present the bank selected for output.
  always_comb begin
    if (pres_sel_q) begin
      bus.win_data = bank_win_s[1];
    end else begin
      bus.win_data = bank_win_s[0];
    end
  end

`else

  loader_state_e    state_q, state_d;
  logic [WIN_W-1:0] bank_win_s;

  window_bank u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (row_xfer_s),
    .wr_idx_i (row_idx_q),
    .wr_row_i (bus.in_row),
    .win_o    (bank_win_s)
  );

  // FILL/FULL next-state and registered handshake targets.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_FILL: begin
        if (win_done_s) begin
          state_d = LD_FULL;
        end else begin
          state_d = LD_FILL;
        end
      end
      LD_FULL: begin
        if (win_xfer_s) begin
          state_d = LD_FILL;
        end else begin
          state_d = LD_FULL;
        end
      end
      default: state_d = LD_FILL;
    endcase
    in_ready_d  = (state_d == LD_FILL);
    win_valid_d = (state_d == LD_FULL);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LD_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.win_data = bank_win_s;

`endif

  // Shared counter and handshake output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_idx_q   <= 4'd0;
      in_ready_q  <= 1'b0;
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      row_idx_q   <= row_idx_d;
      in_ready_q  <= in_ready_d;
      win_valid_q <= win_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.win_valid = win_valid_q;
  assign bus.err       = err_q;

endmodule

// File: doc/ref_window_loader.md
# ref_window_loader

Row-streaming loader that assembles the 15×15 integer-pixel reference window consumed by the subpixel interpolation top level. It accepts one 15-pixel row per beat over a valid/ready stream from the frame-memory fetch path. It packs 15 rows into the 1800-bit window bus and presents each completed window to the interpolator through a valid/ready handshake. It is the producer end of the interpolator's `in_buffer` interface.

## Interface
- `PIXEL_W`, 8, bits per integer pixel
- `WIN_DIM`, 15, pixels per row and rows per window (8 outputs + 7 filter taps)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_row`  in  PIXEL_W*WIN_DIM (120)  one window row; pixel c at bits [c*PIXEL_W +: PIXEL_W]
- `in_valid`  in  1  `in_row`/`in_last` valid
- `in_last`  in  1  marks the final (15th) row of a window
- `in_ready`  out  1  loader can accept a row this cycle
- `win_data`  out  PIXEL_W*WIN_DIM*WIN_DIM (1800)  window; row r at bits [r*120 +: 120]
- `win_valid`  out  1  `win_data` holds a complete window
- `win_ready`  in  1  interpolator accepts the window
- `err`  out  1  one-cycle pulse on a framing error

## Operation
- A row transfers when `in_valid && in_ready`. A window transfers when `win_valid && win_ready`.
- Row counter `row_idx` (4 bits) runs 0..WIN_DIM-1. Each transferred row is written to bank row `row_idx`, then the counter increments. At WIN_DIM-1 the counter wraps to 0 and the bank is marked full.
- FSM (single bank): FILL → FULL when row 14 transfers. FULL → FILL when the window transfers.
- In FILL: `in_ready`=1 and `win_valid`=0. In FULL: `in_ready`=0, `win_valid`=1, and `win_data` stays stable until accepted.
- Framing: if `in_last`=1 on `row_idx`<14, `err` pulses, the partial window is discarded, `row_idx` returns to 0, and nothing is presented.
- Framing: if `in_last`=0 on `row_idx`=14, `err` pulses but the window still completes and is presented.
- `in_row` data on non-transfer cycles is ignored. Bank contents persist, so a discarded row slot is overwritten on the next fill.
- Reset values: `in_ready`=0 while `rst`=0, then 1 from the first cycle after release. `win_valid`=0, `err`=0, `win_data`=0, `row_idx`=0, FSM=FILL.
- Reset mid-window discards all rows and any pending window.

## Timing
- `win_data` and `win_valid` are registered. Row 14 transfers at edge N, and `win_valid`=1 in cycle N+1.
- Best-case throughput: 15 row beats per window, plus 1 cycle (single bank) for the window handshake.
- Single bank: `in_ready` returns to 1 in the cycle after the window transfers.
- `win_valid` must not drop until accepted. `win_ready` held high with no window has no effect.
- `err` asserts in the cycle after the offending row transfers, for exactly one cycle.

## Configuration
- `REF_LOADER_PINGPONG_EN` defined: two banks are instantiated.
  - One bank fills while the other is presented.
  - `in_ready`=0 only when both banks are full.
  - A row transfer and a window transfer in the same cycle are both honoured.
  - Windows are presented in fill order, with no bubble between back-to-back windows.
- `REF_LOADER_PINGPONG_EN` undefined: one bank and the FSM above. `in_ready`=0 throughout FULL.

## Structure
- Shared package `subpel_pkg` holds:
  - `PIXEL_W` and `WIN_DIM`;
  - derived widths `ROW_W`=120 and `WIN_W`=1800;
  - the loader state enum.
- These are shared with the interpolator and the FIR/mux blocks.
- Sub-module `window_bank`: a WIN_DIM×ROW_W register array with row write enable and row index, plus a flat WIN_W read port. It is instantiated once, or twice under `REF_LOADER_PINGPONG_EN`.
- The loader itself holds the FSM, the counter, the bank select and the framing check.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `win_valid`=0, `err`=0, no row captured.
- Basic fill: send rows with pixel(r,c)=r*16+c, `in_last` on row 14, `win_ready`=0.
  - `win_valid`=1 exactly 1 cycle after row 14, and `in_ready`=0.
  - `win_data[(r*15+c)*8 +: 8]` = r*16+c.
- Back-pressure hold: keep `win_ready`=0 for 20 cycles → `win_data` unchanged. Raise `win_ready` for 1 cycle → `win_valid`=0 next cycle and `in_ready`=1.
- Early `in_last` on row 5 → `err` pulses once, no window. The next 15 rows (all 0xAA) produce a window that is entirely 0xAA.
- Missing `in_last` on row 14 → `err` pulses once and the window is still presented intact.
- Ping-pong (macro defined): 3 back-to-back windows of distinct constant value (0x11, 0x22, 0x33), `win_ready`=1 throughout.
  - 45 consecutive row beats, `in_ready` never low.
  - Windows emerge in order with no bubble.
